// File: rtl/axi_wr_ctrl_if.sv
// Bundle of M1 write-path and per-slave AW/W/B handshake signals.
// slave modport is the controller's view; master is the environment's.
interface axi_wr_ctrl_if #(
   parameter int ADDR_BITS = 32,
   parameter int LEN_BITS  = 4
);
   logic [ADDR_BITS-1:0] M1_AWAddr;
   logic [LEN_BITS-1:0]  M1_AWLen;
   logic                 M1_AWValid;
   logic                 M1_AWReady;
   logic                 S0_AWValid;
   logic                 S1_AWValid;
   logic                 DS_AWValid;
   logic                 S0_AWReady;
   logic                 S1_AWReady;
   logic                 DS_AWReady;
   logic [2:0]           W_Sel;
   logic                 Rt_WReady;
   logic                 M1_WValid;
   logic                 M1_WLast;
   logic                 M1_WReady;
   logic                 S0_BValid;
   logic                 S1_BValid;
   logic                 DS_BValid;
   logic [1:0]           S0_BResp;
   logic [1:0]           S1_BResp;
   logic [1:0]           DS_BResp;
   logic                 S0_BReady;
   logic                 S1_BReady;
   logic                 DS_BReady;
   logic                 M1_BValid;
   logic [1:0]           M1_BResp;
   logic                 M1_BReady;

   modport slave (
      input  M1_AWAddr, M1_AWLen, M1_AWValid,
      input  S0_AWReady, S1_AWReady, DS_AWReady,
      input  Rt_WReady, M1_WValid, M1_WLast,
      input  S0_BValid, S1_BValid, DS_BValid,
      input  S0_BResp, S1_BResp, DS_BResp,
      input  M1_BReady,
      output M1_AWReady, S0_AWValid, S1_AWValid, DS_AWValid,
      output W_Sel, M1_WReady,
      output S0_BReady, S1_BReady, DS_BReady,
      output M1_BValid, M1_BResp
   );

   modport master (
      output M1_AWAddr, M1_AWLen, M1_AWValid,
      output S0_AWReady, S1_AWReady, DS_AWReady,
      output Rt_WReady, M1_WValid, M1_WLast,
      output S0_BValid, S1_BValid, DS_BValid,
      output S0_BResp, S1_BResp, DS_BResp,
      output M1_BReady,
      input  M1_AWReady, S0_AWValid, S1_AWValid, DS_AWValid,
      input  W_Sel, M1_WReady,
      input  S0_BReady, S1_BReady, DS_BReady,
      input  M1_BValid, M1_BResp
   );
endinterface

// File: rtl/axi_wr_ctrl.sv
// Single-master AXI write sequencer: AW decode, W beat count, B return.
// One transaction in flight; slave select is held from AW to B.
module axi_wr_ctrl #(
   parameter int ADDR_BITS  = 32,
   parameter int LEN_BITS   = 4,
   parameter int REGION_LSB = 16,
   parameter logic [ADDR_BITS-1:0] S0_BASE = 32'h0000_0000,
   parameter logic [ADDR_BITS-1:0] S1_BASE = 32'h0001_0000
) (
   input logic         clk,
   input logic         rst,
   axi_wr_ctrl_if.slave bus
);

   localparam int HI = ADDR_BITS - 1;

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t              state, state_nxt;
   logic [2:0]          sel;
   logic [LEN_BITS-1:0] len;
   logic [LEN_BITS-1:0] beat_cnt;
   logic                len_err;

   logic [2:0] dec;
   logic [2:0] aw_rdy;
   logic [2:0] b_vld;
   logic [1:0] sel_resp;

   logic [2:0] aw_valid;
   logic       aw_ready;
   logic [2:0] w_sel;
   logic       w_ready;
   logic [2:0] b_ready;
   logic       b_valid;
   logic [1:0] b_resp;
   logic       aw_hs;
   logic       beat;
   logic       b_hs;

   assign aw_rdy = {bus.DS_AWReady, bus.S1_AWReady, bus.S0_AWReady};
   assign b_vld  = {bus.DS_BValid, bus.S1_BValid, bus.S0_BValid};

   // Address region decode; anything unmapped goes to the default slave.
   always_comb begin
      if (bus.M1_AWAddr[HI:REGION_LSB] == S0_BASE[HI:REGION_LSB])
         dec = 3'b001;
      else if (bus.M1_AWAddr[HI:REGION_LSB] == S1_BASE[HI:REGION_LSB])
         dec = 3'b010;
      else
         dec = 3'b100;
   end

   // Response of the latched slave.
   always_comb begin
      sel_resp = 2'b00;
      if (sel[0])
         sel_resp = bus.S0_BResp;
      else if (sel[1])
         sel_resp = bus.S1_BResp;
      else if (sel[2])
         sel_resp = bus.DS_BResp;
   end

   // Next-state and handshake routing; everything quiet while in reset.
   always_comb begin
      state_nxt = state;
      aw_valid  = 3'b000;
      aw_ready  = 1'b0;
      w_sel     = 3'b000;
      w_ready   = 1'b0;
      b_ready   = 3'b000;
      b_valid   = 1'b0;
      b_resp    = 2'b00;
      aw_hs     = 1'b0;
      beat      = 1'b0;
      b_hs      = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               aw_valid = dec & {3{bus.M1_AWValid}};
               aw_ready = |(dec & aw_rdy);
               aw_hs    = bus.M1_AWValid & aw_ready;
               if (aw_hs)
                  state_nxt = DATA;
            end
            DATA: begin
               w_sel   = sel;
               w_ready = bus.Rt_WReady;
               beat    = bus.M1_WValid & bus.Rt_WReady;
               if (beat && beat_cnt == len)
                  state_nxt = RESP;
            end
            RESP: begin
               b_valid = |(sel & b_vld);
               b_ready = sel & {3{bus.M1_BReady}};
               b_resp  = len_err ? 2'b10 : sel_resp;
               b_hs    = b_valid & bus.M1_BReady;
               if (b_hs)
                  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Burst context: select, length, beat count and WLast mismatch flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel      <= 3'b000;
         len      <= '0;
         beat_cnt <= '0;
         len_err  <= 1'b0;
      end else begin
         if (aw_hs) begin
            sel      <= dec;
            len      <= bus.M1_AWLen;
            beat_cnt <= '0;
            len_err  <= 1'b0;
         end
         if (beat) begin
            if (beat_cnt != len) begin
               beat_cnt <= beat_cnt + 1'b1;
               if (bus.M1_WLast)
                  len_err <= 1'b1;
            end else if (!bus.M1_WLast) begin
               len_err <= 1'b1;
            end
         end
         if (b_hs)
            sel <= 3'b000;
      end
   end

   assign bus.S0_AWValid = aw_valid[0];
   assign bus.S1_AWValid = aw_valid[1];
   assign bus.DS_AWValid = aw_valid[2];
   assign bus.M1_AWReady = aw_ready;
   assign bus.W_Sel      = w_sel;
   assign bus.M1_WReady  = w_ready;
   assign bus.S0_BReady  = b_ready[0];
   assign bus.S1_BReady  = b_ready[1];
   assign bus.DS_BReady  = b_ready[2];
   assign bus.M1_BValid  = b_valid;
   assign bus.M1_BResp   = b_resp;

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Bench for axi_wr_ctrl: vector table of write transactions, B responses
// checked through a scoreboard queue, plus reset and ordering sequences.
module tb_axi_wr_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   axi_wr_ctrl_if b ();

   axi_wr_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  len;
      int          delay;
      int          last;
      bit          stall;
      logic [1:0]  sresp;
      logic [2:0]  sel;
      logic [1:0]  exp;
   } vec_t;

   vec_t tbl [7];

   int checks = 0;
   int errors = 0;
   logic [1:0] sb [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every B handshake seen must match the oldest expectation.
   always @(negedge clk) begin
      #2;
      if (b.M1_BValid === 1'b1 && b.M1_BReady === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected: got resp %0h expected none",
                     b.M1_BResp);
         end else begin
            chk("b_resp", {30'd0, b.M1_BResp}, {30'd0, sb.pop_front()});
         end
      end
   end

   function automatic logic [2:0] aw_vec();
      return {b.DS_AWValid, b.S1_AWValid, b.S0_AWValid};
   endfunction

   function automatic logic [2:0] br_vec();
      return {b.DS_BReady, b.S1_BReady, b.S0_BReady};
   endfunction

   task automatic set_aw_rdy(input logic v);
      b.S0_AWReady = v;
      b.S1_AWReady = v;
      b.DS_AWReady = v;
   endtask

   task automatic do_aw(input logic [31:0] addr, input logic [3:0] len,
                        input int delay, input logic [2:0] sel);
      @(negedge clk);
      b.M1_AWAddr  = addr;
      b.M1_AWLen   = len;
      b.M1_AWValid = 1'b1;
      b.Rt_WReady  = 1'b1;
      set_aw_rdy(1'b0);
      for (int i = 0; i < delay; i++) begin
         #1;
         chk("aw_wait_rdy", b.M1_AWReady, 0);
         chk("aw_wait_vld", aw_vec(), sel);
         chk("w_pre_aw", b.M1_WReady, 0);
         @(negedge clk);
      end
      set_aw_rdy(1'b1);
      #1;
      chk("aw_vld", aw_vec(), sel);
      chk("aw_rdy", b.M1_AWReady, 1);
      chk("w_pre_aw", b.M1_WReady, 0);
      @(negedge clk);
      b.M1_AWValid = 1'b0;
      set_aw_rdy(1'b0);
   endtask

   task automatic do_w(input int nbeats, input int last, input bit stall,
                       input logic [2:0] sel);
      b.M1_WValid = 1'b1;
      for (int beat = 0; beat < nbeats; beat++) begin
         if (stall && beat == 1) begin
            b.Rt_WReady = 1'b0;
            b.M1_WLast  = 1'b0;
            #1;
            chk("w_stall", b.M1_WReady, 0);
            @(negedge clk);
            b.Rt_WReady = 1'b1;
         end
         b.M1_WLast = (beat == last);
         #1;
         chk("w_sel", b.W_Sel, sel);
         chk("w_rdy", b.M1_WReady, 1);
         @(negedge clk);
      end
      b.M1_WLast = 1'b0;
   endtask

   task automatic do_b(input logic [2:0] sel, input logic [1:0] sresp);
      b.M1_BReady = 1'b1;
      if (sel == 3'b100) begin
         b.S0_BValid = 1'b1;
         b.S0_BResp  = 2'b01;
      end else begin
         b.DS_BValid = 1'b1;
         b.DS_BResp  = 2'b11;
      end
      #1;
      chk("b_noise", b.M1_BValid, 0);
      chk("b_rdy_sel", br_vec(), sel);
      @(negedge clk);
      if (sel == 3'b001) begin
         b.S0_BValid = 1'b1;
         b.S0_BResp  = sresp;
      end else if (sel == 3'b010) begin
         b.S1_BValid = 1'b1;
         b.S1_BResp  = sresp;
      end else begin
         b.DS_BValid = 1'b1;
         b.DS_BResp  = sresp;
      end
      #1;
      chk("b_vld", b.M1_BValid, 1);
      chk("b_rdy", br_vec(), sel);
      @(negedge clk);
      b.S0_BValid = 1'b0;
      b.S1_BValid = 1'b0;
      b.DS_BValid = 1'b0;
      b.S0_BResp  = 2'b00;
      b.S1_BResp  = 2'b00;
      b.DS_BResp  = 2'b00;
      #1;
      chk("b_idle", b.M1_BValid, 0);
   endtask

   task automatic run_txn(input vec_t v);
      do_aw(v.addr, v.len, v.delay, v.sel);
      sb.push_back(v.exp);
      do_w(int'(v.len) + 1, v.last, v.stall, v.sel);
      #1;
      chk("w_done_rdy", b.M1_WReady, 0);
      chk("w_done_sel", b.W_Sel, 0);
      b.M1_WValid = 1'b0;
      do_b(v.sel, v.sresp);
   endtask

   initial begin
      tbl[0] = '{32'h0000_0040, 4'd3,  0, 3,  1'b0, 2'b00, 3'b001, 2'b00};
      tbl[1] = '{32'h0001_0100, 4'd0,  3, 0,  1'b0, 2'b01, 3'b010, 2'b01};
      tbl[2] = '{32'h8000_0000, 4'd2,  1, 2,  1'b1, 2'b11, 3'b100, 2'b11};
      tbl[3] = '{32'h0000_1000, 4'd3,  0, 1,  1'b0, 2'b00, 3'b001, 2'b10};
      tbl[4] = '{32'h0001_FFFC, 4'd15, 0, 15, 1'b1, 2'b00, 3'b010, 2'b00};
      tbl[5] = '{32'h0002_0000, 4'd1,  0, 99, 1'b0, 2'b00, 3'b100, 2'b10};
      tbl[6] = '{32'h0000_FFFF, 4'd0,  2, 0,  1'b0, 2'b01, 3'b001, 2'b01};

      b.M1_AWAddr  = 32'h0;
      b.M1_AWLen   = 4'd0;
      b.M1_AWValid = 1'b1;
      set_aw_rdy(1'b1);
      b.Rt_WReady  = 1'b1;
      b.M1_WValid  = 1'b1;
      b.M1_WLast   = 1'b0;
      b.S0_BValid  = 1'b1;
      b.S1_BValid  = 1'b1;
      b.DS_BValid  = 1'b1;
      b.S0_BResp   = 2'b11;
      b.S1_BResp   = 2'b11;
      b.DS_BResp   = 2'b11;
      b.M1_BReady  = 1'b1;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_aw_vld", aw_vec(), 0);
      chk("rst_aw_rdy", b.M1_AWReady, 0);
      chk("rst_w_sel", b.W_Sel, 0);
      chk("rst_w_rdy", b.M1_WReady, 0);
      chk("rst_b_vld", b.M1_BValid, 0);
      chk("rst_b_resp", b.M1_BResp, 0);
      chk("rst_b_rdy", br_vec(), 0);

      b.M1_AWValid = 1'b0;
      set_aw_rdy(1'b0);
      b.M1_WValid  = 1'b0;
      b.S0_BValid  = 1'b0;
      b.S1_BValid  = 1'b0;
      b.DS_BValid  = 1'b0;
      b.S0_BResp   = 2'b00;
      b.S1_BResp   = 2'b00;
      b.DS_BResp   = 2'b00;
      b.M1_BReady  = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++)
         run_txn(tbl[i]);

      // W offered before AW: nothing consumed until DATA.
      @(negedge clk);
      b.M1_WValid = 1'b1;
      b.Rt_WReady = 1'b1;
      #1;
      chk("w_early_rdy", b.M1_WReady, 0);
      @(negedge clk);
      #1;
      chk("w_early_rdy2", b.M1_WReady, 0);
      run_txn('{32'h0000_0200, 4'd1, 1, 1, 1'b0, 2'b00, 3'b001, 2'b00});

      // Reset in the middle of a Len=7 burst.
      do_aw(32'h0001_0000, 4'd7, 0, 3'b010);
      do_w(2, 99, 1'b0, 3'b010);
      b.M1_WValid = 1'b1;
      rst = 1'b1;
      #1;
      chk("rst_mid_sel", b.W_Sel, 0);
      chk("rst_mid_rdy", b.M1_WReady, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid_idle_rdy", b.M1_WReady, 0);
      chk("rst_mid_idle_sel", b.W_Sel, 0);
      b.M1_WValid = 1'b0;
      run_txn('{32'h0001_0040, 4'd2, 0, 2, 1'b0, 2'b01, 3'b010, 2'b01});

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
